// File: rtl/morse_decoder_pkg.sv
// ============================================================================
// Module : morse_decoder_pkg
// Brief  : Shared symbol encoding, limits, ASCII codes and FSM states for the
//          Morse receive path.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package morse_decoder_pkg;

    // Symbols are stored LSB-first in order of arrival.
    localparam logic SYM_DOT  = 1'b1;
    localparam logic SYM_DASH = 1'b0;

    localparam int MORSE_MAX_SYMBOLS = 6;

    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_ERR   = 8'h3F;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MARK  = 2'd1,
        ST_SPACE = 2'd2,
        ST_GAP   = 2'd3
    } state_e;

endpackage

`default_nettype wire

// File: rtl/morse_code_to_ascii.sv
// ============================================================================
// Module : morse_code_to_ascii
// Brief  : Combinational lookup from (length, LSB-first dot/dash pattern) to
//          uppercase A-Z / 0-9; hit_o is low for codes outside the alphabet.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_code_to_ascii
    import morse_decoder_pkg::*;
(
    input  logic [3:0]                   len_i,
    input  logic [MORSE_MAX_SYMBOLS-1:0] morse_i,
    output logic [7:0]                   ascii_o,
    output logic                         hit_o
);

    logic [7:0] code_char;

    // Pattern bit 0 is the first symbol received; 1 = dot, 0 = dash.
    always_comb begin
        code_char = 8'h00;
        case ({len_i, morse_i})
            {4'd1, 6'd1}:  code_char = "E";
            {4'd1, 6'd0}:  code_char = "T";
            {4'd2, 6'd1}:  code_char = "A";
            {4'd2, 6'd3}:  code_char = "I";
            {4'd2, 6'd0}:  code_char = "M";
            {4'd2, 6'd2}:  code_char = "N";
            {4'd3, 6'd6}:  code_char = "D";
            {4'd3, 6'd4}:  code_char = "G";
            {4'd3, 6'd2}:  code_char = "K";
            {4'd3, 6'd0}:  code_char = "O";
            {4'd3, 6'd5}:  code_char = "R";
            {4'd3, 6'd7}:  code_char = "S";
            {4'd3, 6'd3}:  code_char = "U";
            {4'd3, 6'd1}:  code_char = "W";
            {4'd4, 6'd14}: code_char = "B";
            {4'd4, 6'd10}: code_char = "C";
            {4'd4, 6'd11}: code_char = "F";
            {4'd4, 6'd15}: code_char = "H";
            {4'd4, 6'd1}:  code_char = "J";
            {4'd4, 6'd13}: code_char = "L";
            {4'd4, 6'd9}:  code_char = "P";
            {4'd4, 6'd4}:  code_char = "Q";
            {4'd4, 6'd7}:  code_char = "V";
            {4'd4, 6'd6}:  code_char = "X";
            {4'd4, 6'd2}:  code_char = "Y";
            {4'd4, 6'd12}: code_char = "Z";
            {4'd5, 6'd0}:  code_char = "0";
            {4'd5, 6'd1}:  code_char = "1";
            {4'd5, 6'd3}:  code_char = "2";
            {4'd5, 6'd7}:  code_char = "3";
            {4'd5, 6'd15}: code_char = "4";
            {4'd5, 6'd31}: code_char = "5";
            {4'd5, 6'd30}: code_char = "6";
            {4'd5, 6'd28}: code_char = "7";
            {4'd5, 6'd24}: code_char = "8";
            {4'd5, 6'd16}: code_char = "9";
            default:       code_char = 8'h00;
        endcase
    end

    assign hit_o   = (code_char != 8'h00);
    assign ascii_o = hit_o ? code_char : ASCII_ERR;

endmodule

`default_nettype wire

// File: rtl/morse_decoder.sv
// ============================================================================
// Module : morse_decoder
// Brief  : Times marks/spaces on a Morse line, assembles up to 6 symbols per
//          letter and emits one ASCII byte per letter plus 8'h20 per word gap.
//          Optional macro MORSE_DECODER_SYNC_EN adds a 2-flop input synchronizer.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module morse_decoder
    import morse_decoder_pkg::*;
#(
    parameter int MORSE_CYCLES = 10
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       morse_i,
    output logic [7:0] ascii_o,
    output logic       valid_o,
    output logic       err_o
);

    localparam int COUNTER_BITS = $clog2(5 * MORSE_CYCLES) + 1;
    localparam int SYM_W        = MORSE_MAX_SYMBOLS;

    localparam logic [COUNTER_BITS-1:0] DASH_MIN_CYCLES   = COUNTER_BITS'(2 * MORSE_CYCLES);
    localparam logic [COUNTER_BITS-1:0] LETTER_GAP_CYCLES = COUNTER_BITS'(2 * MORSE_CYCLES);
    localparam logic [COUNTER_BITS-1:0] WORD_GAP_CYCLES   = COUNTER_BITS'(5 * MORSE_CYCLES);
    localparam logic [COUNTER_BITS-1:0] CNT_ONE           = COUNTER_BITS'(1);
    localparam logic [COUNTER_BITS-1:0] CNT_MAX           = '1;
    localparam logic [3:0]              MAX_LEN           = 4'(MORSE_MAX_SYMBOLS);

    logic line_s;

`ifdef MORSE_DECODER_SYNC_EN
    logic [1:0] sync_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], morse_i};
        end
    end

    assign line_s = sync_q[1];
`else
    assign line_s = morse_i;
`endif

    state_e                  state_q, state_d;
    logic [COUNTER_BITS-1:0] count_q, count_d;
    logic [SYM_W-1:0]        sym_q,   sym_d;
    logic [3:0]              len_q,   len_d;
    logic                    ovf_q,   ovf_d;
    logic                    word_q,  word_d;
    logic [7:0]              ascii_q, ascii_d;
    logic                    valid_q, valid_d;
    logic                    err_q,   err_d;

    logic [COUNTER_BITS-1:0] count_inc;
    logic                    sym_bit;
    logic [7:0]              lut_ascii;
    logic                    lut_hit;
    logic                    letter_ok;

    morse_code_to_ascii u_lut (
        .len_i   (len_q),
        .morse_i (sym_q),
        .ascii_o (lut_ascii),
        .hit_o   (lut_hit)
    );

    assign count_inc = (count_q == CNT_MAX) ? count_q : count_q + CNT_ONE;
    assign sym_bit   = (count_q < DASH_MIN_CYCLES) ? SYM_DOT : SYM_DASH;
    assign letter_ok = lut_hit && !ovf_q;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        sym_d   = sym_q;
        len_d   = len_q;
        ovf_d   = ovf_q;
        word_d  = word_q;
        ascii_d = ascii_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (line_s) begin
                    sym_d   = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = CNT_ONE;
                    state_d = ST_MARK;
                end
            end

            ST_MARK: begin
                if (line_s) begin
                    count_d = count_inc;
                end else begin
                    if (len_q == MAX_LEN) begin
                        ovf_d = 1'b1;
                    end else begin
                        sym_d = sym_q | (SYM_W'(sym_bit) << len_q);
                        len_d = len_q + 4'd1;
                    end
                    count_d = CNT_ONE;
                    state_d = ST_SPACE;
                end
            end

            ST_SPACE: begin
                // A gap of exactly LETTER_GAP_CYCLES ends the letter even if
                // the line rises on the same sample.
                if (count_q == LETTER_GAP_CYCLES) begin
                    ascii_d = letter_ok ? lut_ascii : ASCII_ERR;
                    err_d   = !letter_ok;
                    valid_d = 1'b1;
                    word_d  = 1'b1;
                    count_d = count_inc;
                    state_d = ST_GAP;
                end else if (line_s) begin
                    count_d = CNT_ONE;
                    state_d = ST_MARK;
                end else begin
                    count_d = count_inc;
                end
            end

            ST_GAP: begin
                if (line_s) begin
                    sym_d   = '0;
                    len_d   = '0;
                    ovf_d   = 1'b0;
                    count_d = CNT_ONE;
                    state_d = ST_MARK;
                end else begin
                    count_d = count_inc;
                    if (count_q == WORD_GAP_CYCLES && word_q) begin
                        ascii_d = ASCII_SPACE;
                        valid_d = 1'b1;
                        word_d  = 1'b0;
                    end
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            sym_q   <= '0;
            len_q   <= '0;
            ovf_q   <= 1'b0;
            word_q  <= 1'b0;
            ascii_q <= 8'h00;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sym_q   <= sym_d;
            len_q   <= len_d;
            ovf_q   <= ovf_d;
            word_q  <= word_d;
            ascii_q <= ascii_d;
            valid_q <= valid_d;
            err_q   <= err_d;
        end
    end

    assign ascii_o = ascii_q;
    assign valid_o = valid_q;
    assign err_o   = err_q;

endmodule

`default_nettype wire

// File: tb/tb_morse_decoder.sv
// ============================================================================
// Module : tb_morse_decoder
// Brief  : Directed self-checking bench for morse_decoder with MORSE_CYCLES=4.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_morse_decoder;

    localparam int U = 4;
`ifdef MORSE_DECODER_SYNC_EN
    localparam int SYNC_LAT = 2;
`else
    localparam int SYNC_LAT = 0;
`endif
    localparam int LETTER_LAT = 2 * U + SYNC_LAT;
    localparam int WORD_LAT   = 5 * U + SYNC_LAT;
    localparam int EVMAX      = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic       morse;
    logic [7:0] ascii;
    logic       valid;
    logic       err;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0] ev_ascii [EVMAX];
    logic       ev_err   [EVMAX];
    int         ev_cyc   [EVMAX];
    int         n_ev   = 0;
    logic       consec = 1'b0;

    morse_decoder #(.MORSE_CYCLES(U)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .morse_i (morse),
        .ascii_o (ascii),
        .valid_o (valid),
        .err_o   (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Strobe log: each entry records the cycle index of the edge that raised valid.
    always @(negedge clk) begin
        if (valid === 1'b1) begin
            if (n_ev > 0 && n_ev <= EVMAX && ev_cyc[n_ev-1] == cyc - 1) consec <= 1'b1;
            if (n_ev < EVMAX) begin
                ev_ascii[n_ev] <= ascii;
                ev_err[n_ev]   <= err;
                ev_cyc[n_ev]   <= cyc;
            end
            n_ev <= n_ev + 1;
        end
    end

    task automatic hold(input logic lvl, input int n);
        morse = lvl;
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        morse = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_checks++; if (ascii !== 8'h00) begin n_fail++; $display("FAIL reset_ascii: got %h expected 00", ascii); end
        n_checks++; if (valid !== 1'b0)  begin n_fail++; $display("FAIL reset_valid: got %b expected 0", valid); end
        n_checks++; if (err !== 1'b0)    begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
        rst = 1'b0;
        hold(1'b0, 1);
    endtask

    task automatic test_idle_low();
        int base;
        base = n_ev;
        hold(1'b0, 100);
        n_checks++;
        if (n_ev - base !== 0) begin n_fail++; $display("FAIL idle_low: got %0d strobes expected 0", n_ev - base); end
    endtask

    task automatic test_letter_a();
        int base, fall;
        logic [7:0] exp_c [2];
        int         exp_t [2];
        base = n_ev;
        hold(1'b1, 5); hold(1'b0, 5); hold(1'b1, 13);
        fall = cyc + 1;
        hold(1'b0, 30);
        exp_c = '{8'h41, 8'h20};
        exp_t = '{fall + LETTER_LAT, fall + WORD_LAT};
        n_checks++;
        if (n_ev - base !== 2) begin n_fail++; $display("FAIL A_count: got %0d strobes expected 2", n_ev - base); end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (ev_ascii[base+i] !== exp_c[i] || ev_cyc[base+i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL A_event%0d: got %h at cycle %0d expected %h at cycle %0d",
                         i, ev_ascii[base+i], ev_cyc[base+i], exp_c[i], exp_t[i]);
            end
        end
        n_checks++; if (ev_err[base] !== 1'b0) begin n_fail++; $display("FAIL A_err: got %b expected 0", ev_err[base]); end
        n_checks++; if (ascii !== 8'h20) begin n_fail++; $display("FAIL A_hold: got %h expected 20", ascii); end
    endtask

    task automatic test_threshold();
        int base, fall;
        int         hi    [2];
        logic [7:0] exp_c [2];
        hi    = '{7, 8};
        exp_c = '{8'h45, 8'h54};
        for (int k = 0; k < 2; k++) begin
            base = n_ev;
            hold(1'b1, hi[k]);
            fall = cyc + 1;
            hold(1'b0, 30);
            n_checks++;
            if (n_ev - base !== 2) begin n_fail++; $display("FAIL thr%0d_count: got %0d expected 2", hi[k], n_ev - base); end
            n_checks++;
            if (ev_ascii[base] !== exp_c[k] || ev_err[base] !== 1'b0 || ev_cyc[base] !== fall + LETTER_LAT) begin
                n_fail++;
                $display("FAIL thr%0d_letter: got %h err %b cycle %0d expected %h err 0 cycle %0d",
                         hi[k], ev_ascii[base], ev_err[base], ev_cyc[base], exp_c[k], fall + LETTER_LAT);
            end
        end
    endtask

    task automatic test_word_gap();
        int base;
        base = n_ev;
        hold(1'b1, 4);
        hold(1'b0, 100);
        n_checks++;
        if (n_ev - base !== 2) begin n_fail++; $display("FAIL word_count: got %0d strobes expected 2", n_ev - base); end
        n_checks++;
        if (ev_ascii[base] !== 8'h45 || ev_ascii[base+1] !== 8'h20) begin
            n_fail++;
            $display("FAIL word_seq: got %h %h expected 45 20", ev_ascii[base], ev_ascii[base+1]);
        end
    endtask

    task automatic test_overflow();
        int base, fall;
        base = n_ev;
        fall = 0;
        for (int i = 0; i < 7; i++) begin
            hold(1'b1, 4);
            fall = cyc + 1;
            hold(1'b0, 4);
        end
        hold(1'b0, 26);
        n_checks++;
        if (n_ev - base !== 2) begin n_fail++; $display("FAIL ovf_count: got %0d strobes expected 2", n_ev - base); end
        n_checks++;
        if (ev_ascii[base] !== 8'h3F || ev_err[base] !== 1'b1 || ev_cyc[base] !== fall + LETTER_LAT) begin
            n_fail++;
            $display("FAIL ovf_letter: got %h err %b cycle %0d expected 3f err 1 cycle %0d",
                     ev_ascii[base], ev_err[base], ev_cyc[base], fall + LETTER_LAT);
        end
    endtask

    task automatic test_invalid();
        int base;
        base = n_ev;
        for (int i = 0; i < 6; i++) begin
            hold(1'b1, 8);
            hold(1'b0, 4);
        end
        hold(1'b0, 26);
        n_checks++;
        if (n_ev - base !== 2) begin n_fail++; $display("FAIL inv_count: got %0d strobes expected 2", n_ev - base); end
        n_checks++;
        if (ev_ascii[base] !== 8'h3F || ev_err[base] !== 1'b1) begin
            n_fail++;
            $display("FAIL inv_letter: got %h err %b expected 3f err 1", ev_ascii[base], ev_err[base]);
        end
    endtask

    task automatic test_reset_mid();
        int base;
        base = n_ev;
        hold(1'b1, 4); hold(1'b0, 4); hold(1'b1, 4); hold(1'b0, 2);
        rst = 1'b1;
        #1;
        n_checks++;
        if (ascii !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_async: got %h/%b/%b expected 00/0/0", ascii, valid, err);
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (ascii !== 8'h00 || valid !== 1'b0 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_hold: got %h/%b/%b expected 00/0/0", ascii, valid, err);
        end
        rst = 1'b0;
        hold(1'b0, 5);
        hold(1'b1, 8);
        hold(1'b0, 30);
        n_checks++;
        if (n_ev - base !== 2) begin n_fail++; $display("FAIL rstmid_count: got %0d strobes expected 2", n_ev - base); end
        n_checks++;
        if (ev_ascii[base] !== 8'h54 || ev_err[base] !== 1'b0 || ev_ascii[base+1] !== 8'h20) begin
            n_fail++;
            $display("FAIL rstmid_seq: got %h err %b then %h expected 54 err 0 then 20",
                     ev_ascii[base], ev_err[base], ev_ascii[base+1]);
        end
    endtask

    task automatic test_sos();
        int base;
        int         f     [3];
        logic [7:0] exp_c [4];
        int         exp_t [4];
        base = n_ev;
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 4);
            if (i < 2) hold(1'b0, 4);
        end
        f[0] = cyc + 1;
        hold(1'b0, 3 * U);
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 12);
            if (i < 2) hold(1'b0, 4);
        end
        f[1] = cyc + 1;
        hold(1'b0, 3 * U);
        for (int i = 0; i < 3; i++) begin
            hold(1'b1, 4);
            if (i < 2) hold(1'b0, 4);
        end
        f[2] = cyc + 1;
        hold(1'b0, 7 * U);
        exp_c = '{8'h53, 8'h4F, 8'h53, 8'h20};
        exp_t = '{f[0] + LETTER_LAT, f[1] + LETTER_LAT, f[2] + LETTER_LAT, f[2] + WORD_LAT};
        n_checks++;
        if (n_ev - base !== 4) begin n_fail++; $display("FAIL sos_count: got %0d strobes expected 4", n_ev - base); end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (ev_ascii[base+i] !== exp_c[i] || ev_err[base+i] !== 1'b0 || ev_cyc[base+i] !== exp_t[i]) begin
                n_fail++;
                $display("FAIL sos_event%0d: got %h err %b cycle %0d expected %h err 0 cycle %0d",
                         i, ev_ascii[base+i], ev_err[base+i], ev_cyc[base+i], exp_c[i], exp_t[i]);
            end
        end
    endtask

    task automatic test_no_consec();
        n_checks++;
        if (consec !== 1'b0) begin n_fail++; $display("FAIL valid_consec: got %b expected 0", consec); end
    endtask

    initial begin
        rst   = 1'b1;
        morse = 1'b0;
        test_reset();
        test_idle_low();
        test_letter_a();
        test_threshold();
        test_word_gap();
        test_overflow();
        test_invalid();
        test_reset_mid();
        test_sos();
        test_no_consec();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
